pipeline_hazard_ctrl: RTL and testbench

- Sequences the 5-stage 8-bit pipeline datapath: resolves data hazards through forwarding selects and load-use bubbles, and resolves control hazards for conditional branch, jump, call and return.
- Owns the call-stack depth counter and drives push/pop to the hardware stack.
- Sits beside the main decoder. Consumes opcode and register fields from the IF/ID and ID/EX stages, and drives the datapath's forwarding, PC-select, kill and stack controls.

---
 rtl/pipeline_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage 8-bit pipeline: forwarding selects,
// load-use bubbles, branch/jump/call/return sequencing and return-stack depth.
module pipeline_hazard_ctrl #(
    parameter int         STACK_DEPTH = 8,
    parameter logic [4:0] OP_LOAD     = 5'b00100,
    parameter logic [4:0] OP_JMP      = 5'b10000,
    parameter logic [4:0] OP_JSB      = 5'b10001,
    parameter logic [4:0] OP_RET      = 5'b10010,
    parameter logic [4:0] OP_BZ       = 5'b10100,
    parameter logic [4:0] OP_BNZ      = 5'b10101,
    parameter logic [4:0] OP_BC       = 5'b10110,
    parameter logic [4:0] OP_BNC      = 5'b10111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] command1,
    input  logic [4:0] command2,
    input  logic [2:0] R1_if_dc,
    input  logic [2:0] R2_if_dc,
    input  logic [2:0] Rd_dc_ex,
    input  logic [2:0] Rd_ex_mem,
    input  logic       wr_dc_ex,
    input  logic       wr_ex_mem,
    input  logic       kill_current,
    input  logic       Cff,
    input  logic       Zff,
    output logic [1:0] R1_forward,
    output logic [1:0] R2_forward,
    output logic       hold_fetch,
    output logic       bubble,
    output logic       stallBr,
    output logic [1:0] PCmux,
    output logic [1:0] PCmuxbc,
    output logic       kill_next,
    output logic       push,
    output logic       pop,
    output logic       stack_err
);

    localparam int              DW        = $clog2(STACK_DEPTH + 1);
    localparam logic [DW-1:0]   DEPTH_MAX = DW'(STACK_DEPTH);

    typedef enum logic [1:0] {RUN, BR_WAIT, BR_DECIDE} state_t;

    state_t        state_q, state_d;
    logic [4:0]    br_op_q, br_op_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          stack_err_q, stack_err_d;
    logic          valid;
    logic          load_use;
    logic          taken;

    // A load result is not available in EX, so only non-load producers forward from EX.
    function automatic logic [1:0] fwd_sel(input logic [2:0] src, input logic [4:0] op2,
                                           input logic [2:0] rd_ex, input logic [2:0] rd_mem,
                                           input logic wr_ex, input logic wr_mem);
        if (wr_ex && rd_ex == src && op2 != OP_LOAD)
            return 2'b01;
        else if (wr_mem && rd_mem == src)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        state_d     = state_q;
        br_op_d     = br_op_q;
        depth_d     = depth_q;
        stack_err_d = stack_err_q;
        R1_forward  = 2'b00;
        R2_forward  = 2'b00;
        hold_fetch  = 1'b0;
        bubble      = 1'b0;
        stallBr     = 1'b0;
        PCmux       = 2'b00;
        PCmuxbc     = 2'b00;
        kill_next   = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        valid       = !kill_current;
        load_use    = 1'b0;
        taken       = 1'b0;

        // Every output is forced low while reset is held, independent of the inputs.
        if (rst) begin
            R1_forward = fwd_sel(R1_if_dc, command2, Rd_dc_ex, Rd_ex_mem, wr_dc_ex, wr_ex_mem);
            R2_forward = fwd_sel(R2_if_dc, command2, Rd_dc_ex, Rd_ex_mem, wr_dc_ex, wr_ex_mem);
            load_use   = valid && command2 == OP_LOAD && wr_dc_ex &&
                         (Rd_dc_ex == R1_if_dc || Rd_dc_ex == R2_if_dc);
            if (load_use) begin
                hold_fetch = 1'b1;
                bubble     = 1'b1;
            end

            case (br_op_q)
                OP_BZ:   taken = Zff;
                OP_BNZ:  taken = !Zff;
                OP_BC:   taken = Cff;
                OP_BNC:  taken = !Cff;
                default: taken = 1'b0;
            endcase

            case (state_q)
                RUN: begin
                    // Control instructions held by a load-use stall are acted on once it clears.
                    if (valid && !load_use) begin
                        if (command1 == OP_BZ || command1 == OP_BNZ ||
                            command1 == OP_BC || command1 == OP_BNC) begin
                            hold_fetch = 1'b1;
                            br_op_d    = command1;
                            state_d    = BR_WAIT;
                        end else if (command1 == OP_JMP) begin
                            PCmux     = 2'b10;
                            kill_next = 1'b1;
                        end else if (command1 == OP_JSB) begin
                            PCmux     = 2'b10;
                            kill_next = 1'b1;
                            if (depth_q == DEPTH_MAX) begin
                                stack_err_d = 1'b1;
                            end else begin
                                push    = 1'b1;
                                depth_d = depth_q + DW'(1);
                            end
                        end else if (command1 == OP_RET) begin
                            PCmux     = 2'b11;
                            kill_next = 1'b1;
                            if (depth_q == '0) begin
                                stack_err_d = 1'b1;
                            end else begin
                                pop     = 1'b1;
                                depth_d = depth_q - DW'(1);
                            end
                        end
                    end
                end
                BR_WAIT: begin
                    hold_fetch = 1'b1;
                    state_d    = BR_DECIDE;
                end
                BR_DECIDE: begin
                    stallBr   = 1'b1;
                    PCmuxbc   = taken ? 2'b01 : 2'b00;
                    kill_next = taken;
                    state_d   = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            br_op_q     <= 5'b00000;
            depth_q     <= '0;
            stack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            br_op_q     <= br_op_d;
            depth_q     <= depth_d;
            stack_err_q <= stack_err_d;
        end
    end

    assign stack_err = stack_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

    localparam logic [4:0] NOP  = 5'b00000;
    localparam logic [4:0] ADD  = 5'b00001;
    localparam logic [4:0] LOAD = 5'b00100;
    localparam logic [4:0] JMP  = 5'b10000;
    localparam logic [4:0] JSB  = 5'b10001;
    localparam logic [4:0] RET  = 5'b10010;
    localparam logic [4:0] BZ   = 5'b10100;
    localparam logic [4:0] BNC  = 5'b10111;

    logic       clk;
    logic       rst;
    logic [4:0] command1, command2;
    logic [2:0] R1_if_dc, R2_if_dc, Rd_dc_ex, Rd_ex_mem;
    logic       wr_dc_ex, wr_ex_mem, kill_current, Cff, Zff;
    logic [1:0] R1_forward, R2_forward, PCmux, PCmuxbc;
    logic       hold_fetch, bubble, stallBr, kill_next, push, pop, stack_err;

    int tests_run  = 0;
    int tests_fail = 0;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .command1(command1), .command2(command2),
        .R1_if_dc(R1_if_dc), .R2_if_dc(R2_if_dc),
        .Rd_dc_ex(Rd_dc_ex), .Rd_ex_mem(Rd_ex_mem),
        .wr_dc_ex(wr_dc_ex), .wr_ex_mem(wr_ex_mem),
        .kill_current(kill_current), .Cff(Cff), .Zff(Zff),
        .R1_forward(R1_forward), .R2_forward(R2_forward),
        .hold_fetch(hold_fetch), .bubble(bubble), .stallBr(stallBr),
        .PCmux(PCmux), .PCmuxbc(PCmuxbc), .kill_next(kill_next),
        .push(push), .pop(pop), .stack_err(stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_fail++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_fail++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [4:0] c1, input logic [4:0] c2, input logic kill);
        command1     = c1;
        command2     = c2;
        kill_current = kill;
        @(negedge clk);
    endtask

    task automatic clear_pipe();
        R1_if_dc  = 3'd0; R2_if_dc  = 3'd0;
        Rd_dc_ex  = 3'd0; Rd_ex_mem = 3'd0;
        wr_dc_ex  = 1'b0; wr_ex_mem = 1'b0;
        Cff       = 1'b0; Zff       = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        clear_pipe();
        // Reset with inputs that would otherwise jump and forward
        wr_dc_ex = 1'b1; Rd_dc_ex = 3'd3; R1_if_dc = 3'd3;
        apply_stimulus(JMP, ADD, 1'b0);
        check2("rst_pcmux", PCmux, 2'b00);
        check1("rst_kill_next", kill_next, 1'b0);
        check2("rst_r1_fwd", R1_forward, 2'b00);
        check1("rst_stack_err", stack_err, 1'b0);
        check1("rst_stallbr", stallBr, 1'b0);
        next_cycle();
        rst = 1'b1;
        clear_pipe();

        // Forwarding: EX only, MEM only, both
        wr_dc_ex = 1'b1; Rd_dc_ex = 3'd3; R1_if_dc = 3'd3; R2_if_dc = 3'd1;
        apply_stimulus(NOP, ADD, 1'b0);
        check2("fwd_ex_r1", R1_forward, 2'b01);
        check2("fwd_ex_r2", R2_forward, 2'b00);
        next_cycle();
        wr_dc_ex = 1'b0; wr_ex_mem = 1'b1; Rd_ex_mem = 3'd3;
        apply_stimulus(NOP, ADD, 1'b0);
        check2("fwd_mem_r1", R1_forward, 2'b10);
        next_cycle();
        wr_dc_ex = 1'b1;
        apply_stimulus(NOP, ADD, 1'b0);
        check2("fwd_both_r1", R1_forward, 2'b01);
        next_cycle();

        // A load in EX never forwards from EX; killed consumer causes no stall
        clear_pipe();
        wr_dc_ex = 1'b1; Rd_dc_ex = 3'd4; R1_if_dc = 3'd4;
        apply_stimulus(NOP, LOAD, 1'b1);
        check2("fwd_load_r1", R1_forward, 2'b00);
        check1("killed_no_hold", hold_fetch, 1'b0);
        next_cycle();

        // Load-use with a jump waiting in IF/ID
        clear_pipe();
        wr_dc_ex = 1'b1; Rd_dc_ex = 3'd2; R2_if_dc = 3'd2; R1_if_dc = 3'd0;
        apply_stimulus(JMP, LOAD, 1'b0);
        check1("lu_hold", hold_fetch, 1'b1);
        check1("lu_bubble", bubble, 1'b1);
        check2("lu_pcmux_deferred", PCmux, 2'b00);
        check1("lu_kill_deferred", kill_next, 1'b0);
        next_cycle();
        wr_dc_ex = 1'b0; wr_ex_mem = 1'b1; Rd_ex_mem = 3'd2;
        apply_stimulus(JMP, NOP, 1'b0);
        check1("lu_hold_clear", hold_fetch, 1'b0);
        check1("lu_bubble_clear", bubble, 1'b0);
        check2("lu_r2_fwd_mem", R2_forward, 2'b10);
        check2("lu_jmp_pcmux", PCmux, 2'b10);
        check1("lu_jmp_kill", kill_next, 1'b1);
        next_cycle();
        clear_pipe();
        apply_stimulus(NOP, JMP, 1'b0);
        check2("lu_jmp_once", PCmux, 2'b00);
        next_cycle();

        // BZ taken
        Zff = 1'b1;
        apply_stimulus(BZ, NOP, 1'b0);
        check1("bz_t_c0_hold", hold_fetch, 1'b1);
        check1("bz_t_c0_stallbr", stallBr, 1'b0);
        next_cycle();
        apply_stimulus(BZ, NOP, 1'b0);
        check1("bz_t_c1_hold", hold_fetch, 1'b1);
        check1("bz_t_c1_stallbr", stallBr, 1'b0);
        next_cycle();
        apply_stimulus(BZ, NOP, 1'b0);
        check1("bz_t_c2_stallbr", stallBr, 1'b1);
        check2("bz_t_c2_pcmuxbc", PCmuxbc, 2'b01);
        check1("bz_t_c2_kill", kill_next, 1'b1);
        check1("bz_t_c2_hold", hold_fetch, 1'b0);
        next_cycle();
        apply_stimulus(NOP, NOP, 1'b0);
        check1("bz_t_c3_stallbr", stallBr, 1'b0);
        check1("bz_t_c3_hold", hold_fetch, 1'b0);
        next_cycle();

        // BZ not taken
        Zff = 1'b0;
        apply_stimulus(BZ, NOP, 1'b0);
        next_cycle();
        apply_stimulus(BZ, NOP, 1'b0);
        next_cycle();
        apply_stimulus(BZ, NOP, 1'b0);
        check1("bz_nt_stallbr", stallBr, 1'b1);
        check2("bz_nt_pcmuxbc", PCmuxbc, 2'b00);
        check1("bz_nt_kill", kill_next, 1'b0);
        next_cycle();

        // BNC with carry clear is taken
        Cff = 1'b0;
        apply_stimulus(BNC, NOP, 1'b0);
        next_cycle();
        apply_stimulus(BNC, NOP, 1'b0);
        next_cycle();
        apply_stimulus(BNC, NOP, 1'b0);
        check2("bnc_t_pcmuxbc", PCmuxbc, 2'b01);
        check1("bnc_t_kill", kill_next, 1'b1);
        next_cycle();

        // Nine calls into an eight-entry stack
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(JSB, NOP, 1'b0);
            check1($sformatf("jsb%0d_push", i), push, (i < 8));
            check2($sformatf("jsb%0d_pcmux", i), PCmux, 2'b10);
            check1($sformatf("jsb%0d_err", i), stack_err, 1'b0);
            next_cycle();
        end
        apply_stimulus(NOP, NOP, 1'b0);
        check1("overflow_err", stack_err, 1'b1);
        next_cycle();

        // Nine returns drain the stack, ninth underflows
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(RET, NOP, 1'b0);
            check1($sformatf("ret%0d_pop", i), pop, (i < 8));
            check2($sformatf("ret%0d_pcmux", i), PCmux, 2'b11);
            check1($sformatf("ret%0d_kill", i), kill_next, 1'b1);
            next_cycle();
        end

        // Killed jump and return do nothing
        apply_stimulus(JMP, NOP, 1'b1);
        check2("killed_jmp_pcmux", PCmux, 2'b00);
        check1("killed_jmp_kill", kill_next, 1'b0);
        next_cycle();
        apply_stimulus(RET, NOP, 1'b1);
        check1("killed_ret_pop", pop, 1'b0);
        next_cycle();

        // Three calls, then reset in BR_DECIDE
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(JSB, NOP, 1'b0);
            check1($sformatf("pre_rst_push%0d", i), push, 1'b1);
            next_cycle();
        end
        Zff = 1'b1;
        apply_stimulus(BZ, NOP, 1'b0);
        next_cycle();
        apply_stimulus(BZ, NOP, 1'b0);
        next_cycle();
        apply_stimulus(BZ, NOP, 1'b0);
        check1("pre_rst_stallbr", stallBr, 1'b1);
        #1 rst = 1'b0;
        #1;
        check1("mid_rst_stallbr", stallBr, 1'b0);
        check2("mid_rst_pcmuxbc", PCmuxbc, 2'b00);
        check1("mid_rst_kill", kill_next, 1'b0);
        check1("mid_rst_hold", hold_fetch, 1'b0);
        check1("mid_rst_err", stack_err, 1'b0);
        next_cycle();
        rst = 1'b1;
        apply_stimulus(NOP, NOP, 1'b0);
        check1("post_rst_stallbr", stallBr, 1'b0);
        check1("post_rst_hold", hold_fetch, 1'b0);
        next_cycle();
        // Depth restarted at zero: a return underflows
        apply_stimulus(RET, NOP, 1'b0);
        check1("post_rst_ret_pop", pop, 1'b0);
        check2("post_rst_ret_pcmux", PCmux, 2'b11);
        next_cycle();
        apply_stimulus(JSB, NOP, 1'b0);
        check1("post_rst_underflow_err", stack_err, 1'b1);
        check1("post_rst_jsb_push", push, 1'b1);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
